factorial_ctrl: RTL



---
 rtl/fact_pkg.sv | 16 +
 rtl/factorial_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared FSM states, ALU select codes and limits for the factorial datapath
package fact_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DEC  = 2'd2,
    ST_DONE = 2'd3
  } fact_state_e;

  localparam logic [2:0] ALU_MUL = 3'b000;
  localparam logic [2:0] ALU_DEC = 3'b100;

  localparam int FACT_MAX_N = 5;

endpackage

// File: rtl/factorial_ctrl.sv
// rtl/factorial_ctrl.sv - factorial sequencer driving the ALU; optional FACT_OVF_CHK_EN range short-cut
module factorial_ctrl
  import fact_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MAX_N  = FACT_MAX_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] n_i,
  input  logic [DATA_W-1:0] alu_res_i,
  output logic [DATA_W-1:0] a_alu_o,
  output logic [DATA_W-1:0] b_alu_o,
  output logic [2:0]        sel_alu_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  fact_state_e       state;
  logic [DATA_W-1:0] n_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] result_q;
  logic              accept;
  logic              too_big;
  logic              res_load;

  assign accept = (state == ST_IDLE) && start_i;

`ifdef FACT_OVF_CHK_EN
  localparam logic [DATA_W-1:0] MAX_N_W = DATA_W'(MAX_N);
  assign too_big = (n_i > MAX_N_W);
`else
  assign too_big = 1'b0;
`endif

  // result/ovf load on every transition into DONE, from IDLE (short-cut) or from the final DEC
  assign res_load = (accept && ((n_i <= ONE) || too_big)) ||
                    ((state == ST_DEC) && (alu_res_i == ONE));

  // main sequencer: alternate multiply and decrement until N reaches one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      n_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            n_q   <= n_i;
            acc_q <= ONE;
            if (too_big) begin
              result_q <= '1;
              state    <= ST_DONE;
            end else if (n_i <= ONE) begin
              result_q <= ONE;
              state    <= ST_DONE;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          acc_q <= alu_res_i;
          state <= ST_DEC;
        end
        ST_DEC: begin
          n_q <= alu_res_i;
          if (alu_res_i == ONE) begin
            result_q <= acc_q;
            state    <= ST_DONE;
          end else begin
            state <= ST_MUL;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef FACT_OVF_CHK_EN
  logic ovf_q;

  // overflow flag follows result_o: set only by the out-of-range short-cut
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (res_load) begin
      ovf_q <= accept && too_big;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_load;
  assign unused_load = res_load;
  assign ovf_o       = 1'b0;
`endif

  // ALU drive decoded from registered state only, never from start_i
  always_comb begin
    a_alu_o   = '0;
    b_alu_o   = '0;
    sel_alu_o = ALU_MUL;
    case (state)
      ST_MUL: begin
        a_alu_o   = acc_q;
        b_alu_o   = n_q;
        sel_alu_o = ALU_MUL;
      end
      ST_DEC: begin
        a_alu_o   = n_q;
        sel_alu_o = ALU_DEC;
      end
      default: begin
        a_alu_o   = '0;
        b_alu_o   = '0;
        sel_alu_o = ALU_MUL;
      end
    endcase
  end

  assign busy_o   = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign result_o = result_q;

endmodule
